// File: rtl/wb_pkg.sv
// Shared writeback definitions: mux select codes, stage-3 FSM states and
// a load-select helper. Also used by the writeback mux.
package wb_pkg;

   localparam int WB_SEL_W = 3;
   localparam int CNT_W    = 8;

   // Writeback mux select codes; 110/111 are unassigned and treated as non-load
   localparam logic [WB_SEL_W-1:0] WB_ALU        = 3'b000;
   localparam logic [WB_SEL_W-1:0] WB_LU         = 3'b001;
   localparam logic [WB_SEL_W-1:0] WB_IMM        = 3'b010;
   localparam logic [WB_SEL_W-1:0] WB_IADDER_OUT = 3'b011;
   localparam logic [WB_SEL_W-1:0] WB_CSR        = 3'b100;
   localparam logic [WB_SEL_W-1:0] WB_PC_PLUS    = 3'b101;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_LD_WAIT = 1'b1
   } wb_state_e;

   function automatic logic is_load(input logic [WB_SEL_W-1:0] sel);
      return sel == WB_LU;
   endfunction

endpackage

// File: rtl/wb_ctrl_unit_if.sv
// Stage-2 -> stage-3 control bundle plus the stage-3 control outputs.
interface wb_ctrl_unit_if;
   import wb_pkg::*;

   logic                instr_valid_in;
   logic [WB_SEL_W-1:0] wb_mux_sel_in;
   logic                alu_source_in;
   logic                rf_wr_en_in;
   logic [4:0]          rd_addr_in;
   logic                mem_ready_in;
   logic                flush_in;

   logic [WB_SEL_W-1:0] wb_mux_sel_reg_out;
   logic                alu_source_reg_out;
   logic [4:0]          rd_addr_reg_out;
   logic                rf_wr_en_out;
   logic                stall_out;
   logic                ld_timeout_err_out;

   // Pipeline side: drives stage-2 fields, observes stage-3 controls
   modport master (
      output instr_valid_in, wb_mux_sel_in, alu_source_in, rf_wr_en_in,
             rd_addr_in, mem_ready_in, flush_in,
      input  wb_mux_sel_reg_out, alu_source_reg_out, rd_addr_reg_out,
             rf_wr_en_out, stall_out, ld_timeout_err_out
   );

   // Control unit side
   modport slave (
      input  instr_valid_in, wb_mux_sel_in, alu_source_in, rf_wr_en_in,
             rd_addr_in, mem_ready_in, flush_in,
      output wb_mux_sel_reg_out, alu_source_reg_out, rd_addr_reg_out,
             rf_wr_en_out, stall_out, ld_timeout_err_out
   );

endinterface

// File: rtl/wb_wait_cnt.sv
// Load-wait counter: saturates at MAX, never wraps, flags terminal count.
module wb_wait_cnt
   import wb_pkg::*;
#(
   parameter int unsigned MAX = 15
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic clr_in,
   input  logic load_in,
   input  logic inc_in,
   output logic tc_out
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);

   logic [CNT_W-1:0] cnt;

   // Clear dominates load (start of wait at 1) which dominates increment
   always_ff @(posedge clk_in) begin
      if (rst_in || clr_in)
         cnt <= '0;
      else if (load_in)
         cnt <= CNT_W'(1);
      else if (inc_in && (cnt < CNT_MAX))
         cnt <= cnt + CNT_W'(1);
   end

   assign tc_out = (cnt == CNT_MAX);

endmodule

// File: rtl/wb_ctrl_unit.sv
// Stage-3 writeback control: latches stage-2 control, stalls the front of
// the pipe while a load waits for memory, and aborts the writeback if the
// memory does not answer within TIMEOUT_CYCLES.
module wb_ctrl_unit
   import wb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input logic           clk_in,
   input logic           rst_in,
   wb_ctrl_unit_if.slave bus
);

   wb_state_e           state;
   logic                valid3;
   logic [WB_SEL_W-1:0] sel_reg;
   logic                alu_src_reg;
   logic [4:0]          rd_reg;
   logic                wr_en_reg;

   logic cnt_tc;
   logic stall_run, stall_wait, stall, timeout;

   // Outputs are gated by reset so a load abandoned by reset neither
   // stalls, writes nor flags an error in the reset cycle itself.
   always_comb begin
      stall_run  = (state == ST_RUN) && valid3 && is_load(sel_reg) &&
                   !bus.mem_ready_in && !bus.flush_in;
      stall_wait = (state == ST_LD_WAIT) && !bus.mem_ready_in &&
                   !bus.flush_in && !cnt_tc;
      stall      = !rst_in && (stall_run || stall_wait);
      timeout    = !rst_in && (state == ST_LD_WAIT) && cnt_tc &&
                   !bus.mem_ready_in && !bus.flush_in;
   end

   assign bus.stall_out          = stall;
   assign bus.ld_timeout_err_out = timeout;
   assign bus.rf_wr_en_out       = !rst_in && valid3 && wr_en_reg &&
                                   (rd_reg != 5'd0) && !bus.flush_in &&
                                   (!is_load(sel_reg) || bus.mem_ready_in);

   assign bus.wb_mux_sel_reg_out = sel_reg;
   assign bus.alu_source_reg_out = alu_src_reg;
   assign bus.rd_addr_reg_out    = rd_reg;

   // Any released cycle clears the count, so flush and timeout need no extra path
   wb_wait_cnt #(.MAX(TIMEOUT_CYCLES)) u_wait_cnt (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .clr_in  (!stall),
      .load_in (stall && (state == ST_RUN)),
      .inc_in  (stall && (state == ST_LD_WAIT)),
      .tc_out  (cnt_tc)
   );

   // Stage-3 register and FSM: capture whenever not stalled, hold otherwise
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state       <= ST_RUN;
         valid3      <= 1'b0;
         sel_reg     <= WB_ALU;
         alu_src_reg <= 1'b0;
         rd_reg      <= 5'd0;
         wr_en_reg   <= 1'b0;
      end else if (!stall) begin
         state       <= ST_RUN;
         valid3      <= bus.instr_valid_in && !bus.flush_in && !timeout;
         sel_reg     <= bus.wb_mux_sel_in;
         alu_src_reg <= bus.alu_source_in;
         rd_reg      <= bus.rd_addr_in;
         wr_en_reg   <= bus.rf_wr_en_in;
      end else begin
         state       <= ST_LD_WAIT;
      end
   end

endmodule

// File: tb/tb_wb_ctrl_unit.sv
// Directed bench for wb_ctrl_unit (TIMEOUT_CYCLES=4). Each step drives one
// cycle of inputs and queues the outputs expected in that same cycle; a
// monitor on the falling edge pops and compares.
module tb_wb_ctrl_unit;
   import wb_pkg::*;

   logic clk;
   logic rst;

   wb_ctrl_unit_if bus ();

   wb_ctrl_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   typedef struct {
      string      name;
      logic [2:0] sel;
      logic       alu;
      logic [4:0] rd;
      logic       wr;
      logic       st;
      logic       err;
   } exp_t;

   exp_t sb_q[$];
   exp_t m_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1, "watchdog expired");
   end

   // One cycle: inputs (r v sel alu wr rd mr fl) then expected outputs
   task automatic step(input string name, input int r, input int v, input int s,
                       input int a, input int w, input int rd, input int mr, input int fl,
                       input int es, input int ea, input int erd, input int ew,
                       input int est, input int eerr);
      exp_t e;
      @(posedge clk);
      #1;
      rst                = r[0];
      bus.instr_valid_in = v[0];
      bus.wb_mux_sel_in  = 3'(s);
      bus.alu_source_in  = a[0];
      bus.rf_wr_en_in    = w[0];
      bus.rd_addr_in     = 5'(rd);
      bus.mem_ready_in   = mr[0];
      bus.flush_in       = fl[0];
      e.name = name;
      e.sel  = 3'(es);
      e.alu  = ea[0];
      e.rd   = 5'(erd);
      e.wr   = ew[0];
      e.st   = est[0];
      e.err  = eerr[0];
      sb_q.push_back(e);
   endtask

   // Monitor: compare every queued expectation on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            m_e = sb_q.pop_front();
            n_tests++;
            if ({bus.wb_mux_sel_reg_out, bus.alu_source_reg_out, bus.rd_addr_reg_out,
                 bus.rf_wr_en_out, bus.stall_out, bus.ld_timeout_err_out} !==
                {m_e.sel, m_e.alu, m_e.rd, m_e.wr, m_e.st, m_e.err}) begin
               n_fail++;
               $display("FAIL %s: got sel=%0d alu=%0d rd=%0d wr=%0d stall=%0d err=%0d, expected sel=%0d alu=%0d rd=%0d wr=%0d stall=%0d err=%0d",
                        m_e.name, bus.wb_mux_sel_reg_out, bus.alu_source_reg_out,
                        bus.rd_addr_reg_out, bus.rf_wr_en_out, bus.stall_out,
                        bus.ld_timeout_err_out, m_e.sel, m_e.alu, m_e.rd, m_e.wr,
                        m_e.st, m_e.err);
            end
         end
      end
   end

   initial begin
      rst                = 1'b1;
      bus.instr_valid_in = 1'b0;
      bus.wb_mux_sel_in  = 3'd0;
      bus.alu_source_in  = 1'b0;
      bus.rf_wr_en_in    = 1'b0;
      bus.rd_addr_in     = 5'd0;
      bus.mem_ready_in   = 1'b0;
      bus.flush_in       = 1'b0;

      //       name            r v s a w rd mr fl   es ea erd ew est err
      step("reset_a",          1,1,1,1,1, 9, 0,0,   0, 0, 0, 0, 0, 0);
      step("reset_b",          1,1,3,1,1,31, 1,1,   0, 0, 0, 0, 0, 0);
      step("post_reset",       0,0,0,0,0, 0, 0,0,   0, 0, 0, 0, 0, 0);
      step("alu_issue",        0,1,0,1,1, 5, 0,0,   0, 0, 0, 0, 0, 0);
      step("alu_write",        0,1,0,0,1, 0, 0,0,   0, 1, 5, 1, 0, 0);
      step("x0_suppress",      0,1,1,0,1, 7, 0,0,   0, 0, 0, 0, 0, 0);
      step("ld_stall_1",       0,1,2,1,1,12, 0,0,   1, 0, 7, 0, 1, 0);
      step("ld_stall_2",       0,1,2,1,1,12, 0,0,   1, 0, 7, 0, 1, 0);
      step("ld_stall_3",       0,1,2,1,1,12, 0,0,   1, 0, 7, 0, 1, 0);
      step("ld_complete",      0,1,2,1,1,12, 1,0,   1, 0, 7, 1, 0, 0);
      step("imm_captured",     0,1,1,1,1, 3, 0,0,   2, 1,12, 1, 0, 0);
      step("to_stall_1",       0,0,0,0,0, 0, 0,0,   1, 1, 3, 0, 1, 0);
      step("to_stall_2",       0,0,0,0,0, 0, 0,0,   1, 1, 3, 0, 1, 0);
      step("to_stall_3",       0,0,0,0,0, 0, 0,0,   1, 1, 3, 0, 1, 0);
      step("to_stall_4",       0,0,0,0,0, 0, 0,0,   1, 1, 3, 0, 1, 0);
      step("to_pulse",         0,0,0,0,1, 9, 0,0,   1, 1, 3, 0, 0, 1);
      step("to_single",        0,1,1,0,1,20, 0,0,   0, 0, 9, 0, 0, 0);
      step("fl_stall_1",       0,1,5,1,1, 4, 0,0,   1, 0,20, 0, 1, 0);
      step("fl_stall_2",       0,1,5,1,1, 4, 0,0,   1, 0,20, 0, 1, 0);
      step("flush_wait",       0,1,5,1,1, 4, 1,1,   1, 0,20, 0, 0, 0);
      step("post_flush",       0,1,7,0,1,17, 0,0,   5, 1, 4, 0, 0, 0);
      step("sel111_pass",      0,0,0,0,0, 0, 0,0,   7, 0,17, 1, 0, 0);
      step("idle",             0,1,1,1,1, 8, 0,0,   0, 0, 0, 0, 0, 0);
      step("rw_stall",         0,0,0,0,0, 0, 0,0,   1, 1, 8, 0, 1, 0);
      step("rst_in_wait",      1,0,0,0,0, 0, 1,0,   1, 1, 8, 0, 0, 0);
      step("after_rst_wait",   0,0,0,0,0, 0, 1,0,   0, 0, 0, 0, 0, 0);
      step("ld_issue",         0,1,1,0,1,10, 0,0,   0, 0, 0, 0, 0, 0);
      step("ld_ready_now",     0,0,0,0,0, 0, 1,0,   1, 0,10, 1, 0, 0);
      step("no_stall_after",   0,0,0,0,0, 0, 0,0,   0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
      #1;
      if (sb_q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
